// File: rtl/bram_reverse_behave_pkg.sv
// Shared types and helpers for the ping-pong frame reverser.
package bram_reverse_behave_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      RUN  = 2'd2
   } state_t;

   function automatic int log2c(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/bram_reverse_behave_sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with a LATENCY-deep,
// enable-gated read pipeline. Contents are never reset.
module sdp_ram #(
   parameter int A_WIDTH = 10,
   parameter int D_WIDTH = 32,
   parameter int LATENCY = 2
) (
   input  logic               clk,
   input  logic               en,
   input  logic               we,
   input  logic [A_WIDTH-1:0] waddr,
   input  logic [D_WIDTH-1:0] wdata,
   input  logic [A_WIDTH-1:0] raddr,
   output logic [D_WIDTH-1:0] rdata
);

   localparam int DEPTH = 1 << A_WIDTH;

   logic [D_WIDTH-1:0] mem  [DEPTH];
   logic [D_WIDTH-1:0] pipe [LATENCY];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      if (en) begin
         pipe[0] <= mem[raddr];
         for (int i = 1; i < LATENCY; i++) begin
            pipe[i] <= pipe[i-1];
         end
      end
   end

   assign rdata = pipe[LATENCY-1];

endmodule

// File: rtl/bram_reverse_behave.sv
// Ping-pong frame reverser: writes a frame ascending into one RAM half while
// reading the previous frame descending from the other half.
//
// state | meaning
// IDLE  | waiting for the first sync_in; nothing written, output invalid
// FILL  | writing the first frame after start/resync; output invalid
// RUN   | writing frame k while reading frame k-1 reversed
module bram_reverse_behave
   import bram_reverse_behave_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int FRAME   = 512,
   parameter int LATENCY = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ce,
   input  logic             sync_in,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   output logic             sync_out
);

   localparam int CW = log2c(FRAME);
   localparam int AW = CW + 1;
   localparam logic [CW-1:0] CTR_MAX = CW'(FRAME - 1);

   state_t             state_q, state_d;
   logic [CW-1:0]      ctr_q, ctr_d, wr_ctr;
   logic               bank_q, bank_d, wr_bank;
   logic               wr_en, vld0, sync0, ram_we;
   logic [LATENCY-1:0] vld_sr, sync_sr;
   logic [AW-1:0]      waddr, raddr;
   logic [WIDTH-1:0]   rdata;

   always_comb begin
      state_d = state_q;
      ctr_d   = ctr_q;
      bank_d  = bank_q;
      wr_ctr  = ctr_q;
      wr_bank = bank_q;
      wr_en   = 1'b0;
      vld0    = 1'b0;
      sync0   = 1'b0;
      case (state_q)
         IDLE: begin
            if (sync_in) begin
               wr_en   = 1'b1;
               ctr_d   = CW'(1);
               state_d = FILL;
            end
         end
         FILL, RUN: begin
            wr_en = 1'b1;
            if (sync_in && ctr_q != '0) begin
               // resync: restart at address 0 of the other half; read side
               // follows the effective bank so it never shares the write half
               wr_ctr  = '0;
               wr_bank = ~bank_q;
               bank_d  = ~bank_q;
               ctr_d   = CW'(1);
               state_d = FILL;
            end else begin
               ctr_d = ctr_q + CW'(1);
               vld0  = (state_q == RUN);
               sync0 = (state_q == RUN) && (ctr_q == '0);
               if (ctr_q == CTR_MAX) begin
                  bank_d  = ~bank_q;
                  state_d = RUN;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ctr_q   <= '0;
         bank_q  <= 1'b0;
         vld_sr  <= '0;
         sync_sr <= '0;
      end else if (ce) begin
         state_q    <= state_d;
         ctr_q      <= ctr_d;
         bank_q     <= bank_d;
         vld_sr[0]  <= vld0;
         sync_sr[0] <= sync0;
         for (int i = 1; i < LATENCY; i++) begin
            vld_sr[i]  <= vld_sr[i-1];
            sync_sr[i] <= sync_sr[i-1];
         end
      end
   end

   assign ram_we = ce & wr_en;
   assign waddr  = {wr_bank, wr_ctr};
   assign raddr  = {~wr_bank, CTR_MAX - wr_ctr};

   sdp_ram #(
      .A_WIDTH (AW),
      .D_WIDTH (WIDTH),
      .LATENCY (LATENCY)
   ) u_ram (
      .clk   (clk),
      .en    (ce),
      .we    (ram_we),
      .waddr (waddr),
      .wdata (din),
      .raddr (raddr),
      .rdata (rdata)
   );

   assign dout_valid = vld_sr[LATENCY-1];
   assign sync_out   = sync_sr[LATENCY-1];
   assign dout       = dout_valid ? rdata : '0;

endmodule
